branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Next-generation branch/jump resolution block for the RV32 pipeline, parametrised in data width and predictor depth.
- Resolves B-type, JAL and JALR, computes the target, and registers the result one cycle later.
- Holds a bimodal 2-bit-counter predictor table, read combinationally by fetch and trained on resolution.
- Flags mispredicts and supplies the redirect PC to fetch.

Parameters:
XLEN, 32, data/PC width in bits
PHT_DEPTH, 64, number of 2-bit predictor counters; power of two, ≥2
IDX_W, $clog2(PHT_DEPTH), index width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
pred_pc  in  XLEN  fetch PC for predictor lookup
pred_taken  out  1  combinational: MSB of counter at pred_pc index
res_valid  in  1  resolve request this cycle
res_kind  in  2  00 none, 01 branch, 10 jal, 11 jalr
res_funct3  in  3  branch condition
res_pc  in  XLEN  PC of resolving instruction
res_src1  in  XLEN  rs1 operand
res_src2  in  XLEN  rs2 operand
res_imm  in  XLEN  sign-extended immediate
res_pred_taken  in  1  prediction carried down the pipe
flush  in  1  kill the request presented this cycle
out_valid  out  1  registered result valid
out_taken  out  1  resolved direction
out_target  out  XLEN  computed target
out_redirect_pc  out  XLEN  out_taken ? out_target : pc+4
out_mispredict  out  1  fetch must redirect to out_redirect_pc
out_illegal  out  1  branch with funct3 010/011

Behaviour:
- Reset (async, immediate): all out_* = 0; every PHT counter = 2'b01 (weakly not-taken).
- Accept: a request is live when res_valid & ~flush & res_kind≠00. No backpressure; one request per cycle; latency exactly 1 cycle. All out_* are registered and refreshed every cycle.
- Cycle with no live request: out_valid=0; other out_* = 0.
- Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. 010/011 → taken=0, out_illegal=1, no PHT update.
- Target: branch/jal = res_pc+res_imm; jalr = (res_src1+res_imm) & ~1. All arithmetic is modulo 2^XLEN (wrap, no overflow flag).
- Direction: jal/jalr → taken=1.
- Mispredict: branch → taken≠res_pred_taken; jal → ~res_pred_taken; jalr → always 1 (no target prediction); illegal → 0.
- Index = pc[IDX_W+1:2]; bits [1:0] ignored.
- PHT update on the accept edge, legal branches only: saturating +1 if taken, −1 if not (11 and 00 saturate). jal/jalr do not update.
- Same-index lookup/update in one cycle: pred_taken returns the pre-update value; the new value is visible next cycle.
- flush together with res_valid: request dropped; out_valid=0 next cycle; no PHT update.
- Reset mid-operation discards the in-flight result and reinitialises the whole table.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: adds 32-bit outputs stat_branches (legal accepted branches) and stat_mispredicts (accepted requests with mispredict=1). Both reset to 0, wrap at 2^32, count on the accept edge.
- Undefined: ports and counters absent; all other behaviour unchanged.

Decomposition:
- Shared package/header: res_kind encodings, funct3 condition constants, PHT reset value 2'b01, counter MSB-as-prediction rule.
- One sub-module, branch_cond: combinational XLEN-wide condition evaluator (src1, src2, funct3 → taken, illegal).
- PHT storage, target adders and the output register stay in the top module.

Test Plan:
- Reset, then pred_pc=0x40 → pred_taken=0. Branch beq, src1=src2=5, pc=0x40, imm=0x10, pred=0 → next cycle out_valid=1, taken=1, target=0x50, mispredict=1.
- Two taken branches at pc=0x40 → counter 01→10→11; pred_taken=1 from the cycle after the first update. Third taken → stays 11. Then three not-taken → reaches 00, saturates.
- blt src1=0xFFFFFFFF, src2=1 → taken=1. bltu with same operands → taken=0. funct3=010 → illegal=1, mispredict=0, PHT unchanged.
- jalr src1=0x1003, imm=0x4, pred=1 → target=0x1006, mispredict=1. jal pc=0xFFFFFFFC, imm=8 → target=0x4 (wrap).
- res_valid=1 with flush=1 → out_valid=0 next cycle, counter unchanged. Assert rst mid-stream → outputs 0 immediately, all counters 01.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for branch_resolve_unit: request kinds, branch conditions,
// and the 2-bit saturating predictor counter rules.
package branch_resolve_unit_pkg;

   typedef enum logic [1:0] {
      KIND_NONE   = 2'b00,
      KIND_BRANCH = 2'b01,
      KIND_JAL    = 2'b10,
      KIND_JALR   = 2'b11
   } res_kind_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Weakly not-taken.
   localparam logic [1:0] PHT_RESET = 2'b01;

   function automatic logic ctr_predict(input logic [1:0] ctr);
      return ctr[1];
   endfunction

   function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && ctr != 2'b11) nxt = ctr + 2'd1;
      else if (!taken && ctr != 2'b00) nxt = ctr - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_cond.sv
// Combinational RV32 branch condition evaluator; funct3 010/011 are illegal
// and always resolve not-taken.
module branch_cond
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   input  logic [2:0]      funct3_i,
   output logic            taken_o,
   output logic            illegal_o
);

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  taken_o = (src1_i == src2_i);
         F3_BNE:  taken_o = (src1_i != src2_i);
         F3_BLT:  taken_o = ($signed(src1_i) <  $signed(src2_i));
         F3_BGE:  taken_o = ($signed(src1_i) >= $signed(src2_i));
         F3_BLTU: taken_o = (src1_i <  src2_i);
         F3_BGEU: taken_o = (src1_i >= src2_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with a bimodal 2-bit predictor table and a 1-cycle
// registered result. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PHT_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken,
   input  logic            res_valid,
   input  logic [1:0]      res_kind,
   input  logic [2:0]      res_funct3,
   input  logic [XLEN-1:0] res_pc,
   input  logic [XLEN-1:0] res_src1,
   input  logic [XLEN-1:0] res_src2,
   input  logic [XLEN-1:0] res_imm,
   input  logic            res_pred_taken,
   input  logic            flush,
   output logic            out_valid,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_redirect_pc,
   output logic            out_mispredict,
   output logic            out_illegal
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(PHT_DEPTH);

   res_kind_e       kind;
   logic            live, cond_taken, cond_illegal, pht_upd;
   logic [IDX_W-1:0] pred_idx, res_idx;
   logic [XLEN-1:0] pc_plus_imm, jalr_sum, seq_pc;
   logic [1:0]      pht_q [PHT_DEPTH];

   logic            valid_d, taken_d, misp_d, illegal_d;
   logic [XLEN-1:0] target_d, redirect_d;
   logic            valid_q, taken_q, misp_q, illegal_q;
   logic [XLEN-1:0] target_q, redirect_q;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0], jalr_sum[0]};

   assign kind        = res_kind_e'(res_kind);
   assign live        = res_valid & ~flush & (kind != KIND_NONE);
   assign pred_idx    = pred_pc[IDX_W+1:2];
   assign res_idx     = res_pc[IDX_W+1:2];
   assign pc_plus_imm = res_pc + res_imm;
   assign jalr_sum    = res_src1 + res_imm;
   assign seq_pc      = res_pc + XLEN'(4);
   assign pred_taken  = ctr_predict(pht_q[pred_idx]);
   assign pht_upd     = live & (kind == KIND_BRANCH) & ~cond_illegal;

   branch_cond #(.XLEN(XLEN)) u_branch_cond (
      .src1_i    (res_src1),
      .src2_i    (res_src2),
      .funct3_i  (res_funct3),
      .taken_o   (cond_taken),
      .illegal_o (cond_illegal)
   );

   always_comb begin
      valid_d    = 1'b0;
      taken_d    = 1'b0;
      target_d   = '0;
      redirect_d = '0;
      misp_d     = 1'b0;
      illegal_d  = 1'b0;
      if (live) begin
         valid_d = 1'b1;
         case (kind)
            KIND_BRANCH: begin
               taken_d   = cond_taken;
               target_d  = pc_plus_imm;
               illegal_d = cond_illegal;
               misp_d    = ~cond_illegal & (cond_taken ^ res_pred_taken);
            end
            KIND_JAL: begin
               taken_d  = 1'b1;
               target_d = pc_plus_imm;
               misp_d   = ~res_pred_taken;
            end
            // No target prediction exists, so a jalr always redirects.
            KIND_JALR: begin
               taken_d  = 1'b1;
               target_d = {jalr_sum[XLEN-1:1], 1'b0};
               misp_d   = 1'b1;
            end
            default: ;
         endcase
         redirect_d = taken_d ? target_d : seq_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the table lives in flops, so the async reset clears every entry.
         for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= PHT_RESET;
      end else if (pht_upd) begin
         pht_q[res_idx] <= ctr_train(pht_q[res_idx], cond_taken);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only.
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         target_q   <= '0;
         redirect_q <= '0;
         misp_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         taken_q    <= taken_d;
         target_q   <= target_d;
         redirect_q <= redirect_d;
         misp_q     <= misp_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out_valid       = valid_q;
   assign out_taken       = taken_q;
   assign out_target      = target_q;
   assign out_redirect_pc = redirect_q;
   assign out_mispredict  = misp_q;
   assign out_illegal     = illegal_q;

`ifdef BRU_STATS_EN
   logic [31:0] stat_branches_q, stat_mispredicts_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         if (pht_upd) stat_branches_q    <= stat_branches_q + 32'd1;
         if (misp_d)  stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
